// File: rtl/add_pipe_hs.sv
// Handshaked W-bit adder/subtractor with a STAGES-deep elastic pipeline.
// Supports wrapping and saturating add/sub, an overflow flag, a transaction counter and a sticky done flag.
module add_pipe_hs #(
  parameter int W      = 10,
  parameter int STAGES = 2,
  parameter int CW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [1:0]    op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  y,
  output logic          ovf,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // a producer holds valid and its payload until that edge, and ready never depends on valid.

  localparam int S = STAGES;

  logic [S-1:0]  vld;
  logic [S-1:0]  ovf_q;
  logic [W-1:0]  y_q [S];
  logic [S-1:0]  load;
  logic          full_from;

  logic [W:0]    sum_w;
  logic [W:0]    diff_w;
  logic [W-1:0]  res_y;
  logic          res_ovf;

  logic          fire_out;
  logic [CW-1:0] count_q;
  logic          done_q;

  // The extra top bit of the W+1-bit sum is the carry; of the difference, the borrow.
  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    diff_w  = {1'b0, a} - {1'b0, b};
    res_y   = '0;
    res_ovf = 1'b0;
    case (op)
      2'b00: begin
        res_y   = sum_w[W-1:0];
        res_ovf = sum_w[W];
      end
      2'b01: begin
        res_y   = diff_w[W-1:0];
        res_ovf = diff_w[W];
      end
      2'b10: begin
        res_y   = sum_w[W] ? {W{1'b1}} : sum_w[W-1:0];
        res_ovf = sum_w[W];
      end
      default: begin
        res_y   = diff_w[W] ? {W{1'b0}} : diff_w[W-1:0];
        res_ovf = diff_w[W];
      end
    endcase
  end

  // Slot k may load unless it and every slot after it are full while the output stalls.
  always_comb begin
    full_from = 1'b1;
    load      = '0;
    for (int k = S - 1; k >= 0; k--) begin
      full_from = full_from & vld[k];
      load[k]   = !full_from || out_ready;
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld[S-1];
  assign y         = y_q[S-1];
  assign ovf       = ovf_q[S-1];
  assign busy      = |vld;
  assign fire_out  = vld[S-1] && out_ready;
  assign count     = count_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= '0;
      ovf_q   <= '0;
      for (int k = 0; k < S; k++) begin
        y_q[k] <= '0;
      end
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      if (load[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          y_q[0]   <= res_y;
          ovf_q[0] <= res_ovf;
        end
      end
      for (int k = 1; k < S; k++) begin
        if (load[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            y_q[k]   <= y_q[k-1];
            ovf_q[k] <= ovf_q[k-1];
          end
        end
      end
      if (fire_out) begin
        count_q <= count_q + CW'(1);
        done_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add_pipe_hs.sv
// Bench for add_pipe_hs: directed boundary/backpressure/reset cases plus random traffic,
// all results checked against an arithmetic reference model and an expected-result queue.
module tb_add_pipe_hs;

  localparam int W      = 10;
  localparam int STAGES = 2;
  localparam int CW     = 16;
  localparam int CW2    = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     op = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   y;
  logic           ovf;
  logic           busy;
  logic           done;
  logic [CW-1:0]  count;

  logic           in_ready_c4;
  logic           out_valid_c4;
  logic [W-1:0]   y_c4;
  logic           ovf_c4;
  logic           busy_c4;
  logic           done_c4;
  logic [CW2-1:0] count_c4;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0] exp_q[$];
  int         inflight    = 0;
  int         model_count = 0;
  bit         model_done  = 0;
  bit         prev_stall  = 0;
  logic [W-1:0] prev_y    = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  add_pipe_hs #(.W(W), .STAGES(STAGES), .CW(CW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .ovf(ovf), .busy(busy), .done(done), .count(count)
  );

  add_pipe_hs #(.W(W), .STAGES(STAGES), .CW(CW2)) u_dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c4),
    .a(a), .b(b), .op(op), .out_valid(out_valid_c4), .out_ready(out_ready),
    .y(y_c4), .ovf(ovf_c4), .busy(busy_c4), .done(done_c4), .count(count_c4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operation rules.
  function automatic logic [W:0] ref_result(input int ua, input int ub, input int uop);
    int maxv;
    int s;
    int d;
    int ry;
    bit rovf;
    maxv = (1 << W) - 1;
    s = ua + ub;
    d = ua - ub;
    case (uop)
      0: begin ry = s % (1 << W);           rovf = (s > maxv); end
      1: begin ry = (d + (1 << W)) % (1 << W); rovf = (ua < ub); end
      2: begin ry = (s > maxv) ? maxv : s;  rovf = (s > maxv); end
      default: begin ry = (d < 0) ? 0 : d;  rovf = (d < 0); end
    endcase
    return {rovf, ry[W-1:0]};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      inflight    = 0;
      model_count = 0;
      model_done  = 0;
      prev_stall  = 0;
    end else begin
      check("in_ready", in_ready, (inflight < STAGES) || out_ready);
      check("busy", busy, inflight > 0);
      check("count", count, model_count % (1 << CW));
      check("count_c4", count_c4, model_count % (1 << CW2));
      check("done", done, model_done);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_y", y, prev_y);
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", out_valid, 0);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("y", y, e[W-1:0]);
          check("ovf", ovf, e[W]);
          check("y_c4", y_c4, e[W-1:0]);
        end
        model_count++;
        model_done = 1;
        inflight--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_result(a, b, op));
        inflight++;
      end
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input int ua, input int ub, input int uop);
    bit acc;
    acc = 0;
    a = W'(ua); b = W'(ub); op = 2'(uop);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    check("wait_timeout", out_valid, 1);
  endtask

  task automatic send_expect(input int ua, input int ub, input int uop,
                             input int ey, input int eovf, input string tag);
    send(ua, ub, uop);
    wait_out();
    check({tag, "_y"}, y, ey);
    check({tag, "_ovf"}, ovf, eovf);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    int first_cyc;
    int last_cyc;
    bit acc;
    bit stale;
    logic [W-1:0] got_q[$];

    repeat (3) @(posedge clk);
    #1;
    do_reset();

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_ovf", ovf, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // basic latency
    out_ready = 1'b1;
    send(3, 4, 0);
    @(negedge clk);
    check("lat_early", out_valid, 0);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("basic_y", y, 7);
    check("basic_ovf", ovf, 0);
    @(negedge clk);
    check("basic_count", count, 1);
    check("basic_done", done, 1);
    @(posedge clk); #1;

    // arithmetic boundaries
    send_expect(1023, 1, 0, 0, 1, "addw_ovf");
    send_expect(1023, 1, 2, 1023, 1, "adds_clamp");
    send_expect(5, 9, 1, 1020, 1, "subw_borrow");
    send_expect(5, 9, 3, 0, 1, "subs_clamp");
    send_expect(512, 511, 2, 1023, 0, "adds_edge");
    send_expect(512, 511, 0, 1023, 0, "addw_edge");
    send_expect(7, 7, 1, 0, 0, "subw_eq");
    send_expect(7, 7, 3, 0, 0, "subs_eq");

    // backpressure
    do_reset();
    out_ready = 1'b0;
    idx = 1;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      a = W'(idx); b = W'(idx); op = 2'b00;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    check("bp_accepts", idx - 1, 2);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_y_held", y, 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    got_q.delete();
    for (int c = 0; c < 30 && got_q.size() < 5; c++) begin
      in_valid = (idx <= 5);
      a = W'(idx); b = W'(idx); op = 2'b00;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) got_q.push_back(y);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_n_out", got_q.size(), 5);
    for (int i = 0; i < got_q.size(); i++) check("bp_order", got_q[i], 2 * (i + 1));
    @(negedge clk);
    check("bp_count", count, 5);
    @(posedge clk); #1;

    // streaming
    do_reset();
    out_ready = 1'b1;
    got_q.delete();
    first_cyc = -1;
    last_cyc  = -1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      a = W'(c); b = '0; op = 2'b00;
      @(negedge clk);
      if (c < 8) check("stream_ready", in_ready, 1);
      if (out_valid) begin
        got_q.push_back(y);
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream_n_out", got_q.size(), 8);
    check("stream_no_gap", last_cyc - first_cyc, 7);
    for (int i = 0; i < got_q.size(); i++) check("stream_y", got_q[i], i);
    @(negedge clk);
    check("stream_count", count, 8);
    @(posedge clk); #1;

    // reset with transactions in flight
    out_ready = 1'b0;
    send(1, 2, 0);
    send(3, 4, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_y", y, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale = 1;
    end
    check("no_stale", stale, 0);
    @(posedge clk); #1;

    // counter wrap on the CW=4 instance
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 21; c++) begin
      in_valid = (c < 17);
      a = W'($urandom_range(0, 1023)); b = W'($urandom_range(0, 1023));
      op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("wrap_count_c4", count_c4, 1);
    check("wrap_done_c4", done_c4, 1);
    check("wrap_count", count, 17);
    @(posedge clk); #1;

    // random traffic with random backpressure
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0) begin
        a = W'($urandom_range(1000, 1023));
        b = W'($urandom_range(0, 30));
      end else begin
        a = W'($urandom_range(0, 1023));
        b = W'($urandom_range(0, 1023));
      end
      op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("drain_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
